cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of result producers; index 0=alu, 1=mul, 2=br, 3=mem.
REQ-002 Parameter FIFO_DEPTH, default 2, result-buffer entries per producer; power of two, >=2.
REQ-003 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 flush  in  1  synchronous pipeline flush (mispredict).
REQ-006 src_valid  in  NUM_SRC  per-producer result valid.
REQ-007 src_ready  out  NUM_SRC  per-producer buffer can accept.
REQ-008 src_rob_idx  in  NUM_SRC x 5  ROB index of each result.
REQ-009 src_rd_addr  in  NUM_SRC x 5  destination arch register.
REQ-010 src_data  in  NUM_SRC x 32  result value.
REQ-011 src_regf_we  in  NUM_SRC  result writes register file.
REQ-012 cdb_valid  out  1  broadcast valid this cycle.
REQ-013 cdb_src  out  2  index of broadcasting producer.
REQ-014 cdb_rob_idx  out  5; cdb_rd_addr  out  5; cdb_data  out  32; cdb_regf_we  out  1: broadcast payload.

Function
REQ-015 Each producer SHALL own a FIFO_DEPTH-entry FIFO with a count from 0 to FIFO_DEPTH and wrapping read/write pointers.
REQ-016 src_ready[i] SHALL equal (count[i] < FIFO_DEPTH), with no dependence on a same-cycle pop.
REQ-017 A push SHALL occur when src_valid[i] && src_ready[i] && !flush; src_valid with src_ready low SHALL be ignored; producers hold payload until ready.
REQ-018 Simultaneous push and pop on one FIFO SHALL leave count unchanged and write/read distinct slots.
REQ-019 The arbiter SHALL grant at most one non-empty FIFO per cycle, in round-robin order starting at (last_grant+1) mod NUM_SRC.
REQ-020 cdb_valid SHALL be 1 when any FIFO is non-empty and flush is 0; payload and cdb_src SHALL come combinationally from the granted FIFO head.
REQ-021 When cdb_valid is 0, cdb_src and all payload outputs SHALL be 0.
REQ-022 The granted FIFO SHALL pop at the clock edge ending the broadcast cycle; last_grant SHALL update to the granted index.
REQ-023 No bypass: a result pushed at edge N SHALL broadcast no earlier than the cycle following edge N; minimum latency 1 cycle.
REQ-024 Each pushed result SHALL be broadcast exactly once, in per-producer FIFO order, unless discarded by flush or reset.
REQ-025 Any non-empty FIFO SHALL be granted within NUM_SRC cycles.
REQ-026 A flush SHALL clear all counts and pointers at the edge, drop same-cycle pushes, force cdb_valid=0 in the flush cycle, and reset last_grant to NUM_SRC-1.
REQ-027 A FIFO at count=FIFO_DEPTH that is granted SHALL drop to FIFO_DEPTH-1 and assert src_ready the following cycle.
REQ-028 last_grant SHALL not change in a cycle with no grant.

Reset
REQ-029 rst SHALL asynchronously clear all FIFO counts and pointers and set last_grant=NUM_SRC-1.
REQ-030 During and immediately after reset: cdb_valid=0, all payload outputs 0, src_ready all 1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered results; none SHALL broadcast after release.

Verification
REQ-032 Single push: alu pushes rob 3, rd x5, data 0xDEAD_BEEF at edge 0 -> cycle 1 cdb_valid=1, cdb_src=0, payload matches; cycle 2 cdb_valid=0.
REQ-033 Contention: all four producers push at edge 0 with rob 1,2,3,4 -> broadcasts at cycles 1-4 in src order 0,1,2,3; then alu pushes again -> granted after src 3, in order.
REQ-034 Backpressure: mul pushes 3 consecutive cycles while alu hogs the grant -> src_ready[1]=0 after 2 accepts; third result held; all three broadcast in order.
REQ-035 Flush: mem FIFO holds 2 entries, flush=1 with a simultaneous br push -> cdb_valid=0 that cycle; nothing broadcast afterward; src_ready all 1.
REQ-036 Async reset: rst asserted between edges with 3 FIFOs non-empty -> outputs zero immediately without a clock edge; no broadcast after release.
REQ-037 Scoreboard: random valid/flush traffic over 10k cycles -> every accepted, unflushed result broadcast exactly once, per-source order held, no starvation beyond 4 cycles.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: each producer owns a small result FIFO and one
// head entry per cycle is broadcast on the CDB, chosen round-robin.
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [NUM_SRC-1:0]                 src_valid,
    output logic [NUM_SRC-1:0]                 src_ready,
    input  logic [NUM_SRC-1:0][4:0]            src_rob_idx,
    input  logic [NUM_SRC-1:0][4:0]            src_rd_addr,
    input  logic [NUM_SRC-1:0][31:0]           src_data,
    input  logic [NUM_SRC-1:0]                 src_regf_we,
    output logic                               cdb_valid,
    output logic [$clog2(NUM_SRC)-1:0]         cdb_src,
    output logic [4:0]                         cdb_rob_idx,
    output logic [4:0]                         cdb_rd_addr,
    output logic [31:0]                        cdb_data,
    output logic                               cdb_regf_we
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 5 + 5 + 32 + 1;

    logic [NUM_SRC-1:0] nonEmpty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [ENT_W-1:0]   head [NUM_SRC];
    logic [SRC_W-1:0]   lastGrant_q;
    logic [SRC_W-1:0]   lastGrant_d;
    logic [SRC_W-1:0]   gntIdx;
    logic               gntFound;
    logic               gntValid;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic [PTR_W-1:0] wptr_q;
        logic [PTR_W-1:0] rptr_q;
        logic [ENT_W-1:0] mem_q [FIFO_DEPTH];

        // Ready looks only at the registered count, never at this cycle's pop.
        assign src_ready[g] = (count_q < CNT_W'(FIFO_DEPTH));
        assign nonEmpty[g]  = (count_q != '0);
        assign push[g]      = src_valid[g] && src_ready[g] && !flush;
        assign pop[g]       = gntValid && (gntIdx == SRC_W'(g));
        assign head[g]      = mem_q[rptr_q];

        always_comb begin
            count_d = count_q;
            case ({push[g], pop[g]})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else if (flush) begin
                count_q <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
            end else begin
                count_q <= count_d;
                if (push[g]) wptr_q <= wptr_q + PTR_W'(1);
                if (pop[g])  rptr_q <= rptr_q + PTR_W'(1);
            end
        end

        // Storage needs no reset: an entry is only visible once count covers it.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wptr_q] <= {src_rob_idx[g], src_rd_addr[g], src_data[g], src_regf_we[g]};
            end
        end
    end

    // Search starts one past the last winner so every producer gets a turn.
    always_comb begin
        logic [SRC_W:0] cand;
        gntFound = 1'b0;
        gntIdx   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, lastGrant_q} + (SRC_W + 1)'(k);
            if (cand >= (SRC_W + 1)'(NUM_SRC)) cand = cand - (SRC_W + 1)'(NUM_SRC);
            if (!gntFound && nonEmpty[cand[SRC_W-1:0]]) begin
                gntFound = 1'b1;
                gntIdx   = cand[SRC_W-1:0];
            end
        end
    end

    assign gntValid = gntFound && !flush;

    always_comb begin
        cdb_valid = gntValid;
        cdb_src   = '0;
        {cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we} = '0;
        if (gntValid) begin
            cdb_src = gntIdx;
            {cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we} = head[gntIdx];
        end
    end

    always_comb begin
        lastGrant_d = lastGrant_q;
        if (flush)         lastGrant_d = SRC_W'(NUM_SRC - 1);
        else if (gntValid) lastGrant_d = gntIdx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lastGrant_q <= SRC_W'(NUM_SRC - 1);
        else     lastGrant_q <= lastGrant_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DEPTH   = 2;

    typedef struct packed {
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } ent_t;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC-1:0][4:0]   src_rob_idx;
    logic [NUM_SRC-1:0][4:0]   src_rd_addr;
    logic [NUM_SRC-1:0][31:0]  src_data;
    logic [NUM_SRC-1:0]        src_regf_we;
    logic                      cdb_valid;
    logic [1:0]                cdb_src;
    logic [4:0]                cdb_rob_idx;
    logic [4:0]                cdb_rd_addr;
    logic [31:0]               cdb_data;
    logic                      cdb_regf_we;

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_rob_idx (src_rob_idx),
        .src_rd_addr (src_rd_addr),
        .src_data    (src_data),
        .src_regf_we (src_regf_we),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_rd_addr (cdb_rd_addr),
        .cdb_data    (cdb_data),
        .cdb_regf_we (cdb_regf_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: accepted-but-not-broadcast results per producer, plus last winner.
    ent_t mq [NUM_SRC][$];
    int   mLast;
    int   waitCnt [NUM_SRC];

    int   checkCount;
    int   passCount;

    ent_t               drvEnt [NUM_SRC];
    logic               obsValid;
    logic [1:0]         obsSrc;
    ent_t               obsEnt;
    logic [NUM_SRC-1:0] obsReady;
    logic [NUM_SRC-1:0] acc;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        else
            passCount++;
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_SRC; i++) begin
            mq[i].delete();
            waitCnt[i] = 0;
        end
        mLast = NUM_SRC - 1;
    endtask

    // Drives one cycle, checks every output against the model, then advances the model at the edge.
    task automatic applyStimulus(input logic [NUM_SRC-1:0] v, input logic f, output logic [NUM_SRC-1:0] accepted);
        logic               expValid;
        int                 expSrc;
        ent_t               expEnt;
        logic [NUM_SRC-1:0] expReady;
        int                 s;
        @(negedge clk);
        src_valid = v;
        flush     = f;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rob_idx[i] = drvEnt[i].rob;
            src_rd_addr[i] = drvEnt[i].rd;
            src_data[i]    = drvEnt[i].data;
            src_regf_we[i] = drvEnt[i].we;
        end
        #1;
        for (int i = 0; i < NUM_SRC; i++) expReady[i] = (mq[i].size() < DEPTH);
        expValid = 1'b0;
        expSrc   = 0;
        expEnt   = '0;
        if (!f) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                s = (mLast + k) % NUM_SRC;
                if (!expValid && mq[s].size() > 0) begin
                    expValid = 1'b1;
                    expSrc   = s;
                    expEnt   = mq[s][0];
                end
            end
        end
        obsValid = cdb_valid;
        obsSrc   = cdb_src;
        obsEnt   = {cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we};
        obsReady = src_ready;
        checkOutput("src_ready", 64'(obsReady), 64'(expReady));
        checkOutput("cdb_valid", 64'(obsValid), 64'(expValid));
        checkOutput("cdb_src", 64'(obsSrc), 64'(expSrc));
        checkOutput("cdb_payload", 64'(obsEnt), 64'(expEnt));
        for (int i = 0; i < NUM_SRC; i++) begin
            if (obsValid && int'(obsSrc) == i) begin
                checkOutput("starvation", 64'(waitCnt[i] < NUM_SRC), 64'(1));
                waitCnt[i] = 0;
            end else if (!f && mq[i].size() > 0) begin
                waitCnt[i]++;
            end else begin
                waitCnt[i] = 0;
            end
        end
        accepted = v & expReady & {NUM_SRC{!f}};
        @(posedge clk);
        if (f) begin
            clearModel();
        end else begin
            if (expValid) begin
                void'(mq[expSrc].pop_front());
                mLast = expSrc;
            end
            for (int i = 0; i < NUM_SRC; i++)
                if (accepted[i]) mq[i].push_back(drvEnt[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus('0, 1'b0, acc);
    endtask

    logic [NUM_SRC-1:0] pendValid;
    int                 modelLeft;
    int                 seq;
    int                 expOrder [6];
    int                 expRob [6];

    initial begin
        checkCount = 0;
        passCount  = 0;
        seq        = 0;
        clearModel();
        for (int i = 0; i < NUM_SRC; i++) drvEnt[i] = '0;
        rst         = 1'b1;
        flush       = 1'b0;
        src_valid   = '0;
        src_rob_idx = '0;
        src_rd_addr = '0;
        src_data    = '0;
        src_regf_we = '0;

        // Outputs while reset is held.
        #1;
        checkOutput("reset_valid", 64'(cdb_valid), 64'(0));
        checkOutput("reset_ready", 64'(src_ready), 64'(4'hF));
        checkOutput("reset_payload", 64'({cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single alu result, visible the cycle after it is pushed and gone the cycle after that.
        drvEnt[0] = '{rob: 5'd3, rd: 5'd5, data: 32'hDEAD_BEEF, we: 1'b1};
        applyStimulus(4'b0001, 1'b0, acc);
        checkOutput("single_no_bypass", 64'(obsValid), 64'(0));
        applyStimulus(4'b0000, 1'b0, acc);
        checkOutput("single_valid", 64'(obsValid), 64'(1));
        checkOutput("single_src", 64'(obsSrc), 64'(0));
        checkOutput("single_data", 64'(obsEnt.data), 64'(32'hDEAD_BEEF));
        applyStimulus(4'b0000, 1'b0, acc);
        checkOutput("single_after", 64'(obsValid), 64'(0));

        // All four push together, alu pushes again while its first result broadcasts.
        applyStimulus('0, 1'b1, acc);
        for (int i = 0; i < NUM_SRC; i++) drvEnt[i] = '{rob: 5'(i + 1), rd: 5'(i + 10), data: 32'(i * 100), we: 1'b1};
        applyStimulus(4'b1111, 1'b0, acc);
        expOrder = '{0, 1, 2, 3, 0, 0};
        expRob   = '{1, 2, 3, 4, 9, 0};
        drvEnt[0].rob = 5'd9;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c == 0 ? 4'b0001 : 4'b0000, 1'b0, acc);
            checkOutput("contend_valid", 64'(obsValid), 64'(c < 5));
            checkOutput("contend_src", 64'(obsSrc), 64'(expOrder[c]));
            checkOutput("contend_rob", 64'(obsEnt.rob), 64'(expRob[c]));
        end

        // Mul fills while alu keeps competing; third mul result must wait for space.
        applyStimulus('0, 1'b1, acc);
        drvEnt[0].rob = 5'd20;
        drvEnt[1].rob = 5'd11;
        applyStimulus(4'b0011, 1'b0, acc);
        drvEnt[0].rob = 5'd21;
        drvEnt[1].rob = 5'd12;
        applyStimulus(4'b0011, 1'b0, acc);
        drvEnt[0].rob = 5'd22;
        drvEnt[1].rob = 5'd13;
        applyStimulus(4'b0011, 1'b0, acc);
        checkOutput("bp_ready_low", 64'(obsReady[1]), 64'(0));
        checkOutput("bp_held", 64'(acc[1]), 64'(0));
        applyStimulus(4'b0010, 1'b0, acc);
        checkOutput("bp_accept_third", 64'(acc[1]), 64'(1));
        idle(6);

        // Mem holds two entries when flush arrives together with a br push.
        applyStimulus('0, 1'b1, acc);
        drvEnt[0].rob = 5'd30;
        drvEnt[3].rob = 5'd31;
        applyStimulus(4'b1001, 1'b0, acc);
        drvEnt[3].rob = 5'd32;
        applyStimulus(4'b1000, 1'b0, acc);
        drvEnt[2].rob = 5'd33;
        applyStimulus(4'b0100, 1'b1, acc);
        checkOutput("flush_valid", 64'(obsValid), 64'(0));
        for (int c = 0; c < 3; c++) begin
            applyStimulus('0, 1'b0, acc);
            checkOutput("post_flush_valid", 64'(obsValid), 64'(0));
            checkOutput("post_flush_ready", 64'(obsReady), 64'(4'hF));
        end

        // Reset between edges with three FIFOs occupied.
        applyStimulus(4'b0111, 1'b0, acc);
        @(negedge clk);
        src_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", 64'(cdb_valid), 64'(0));
        checkOutput("async_ready", 64'(src_ready), 64'(4'hF));
        checkOutput("async_payload", 64'({cdb_src, cdb_rob_idx, cdb_rd_addr, cdb_data, cdb_regf_we}), 64'(0));
        clearModel();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus('0, 1'b0, acc);
            checkOutput("after_reset_valid", 64'(obsValid), 64'(0));
        end

        // Random traffic; producers hold a result until it is accepted.
        pendValid = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!pendValid[i] && $urandom_range(0, 99) < 45) begin
                    seq++;
                    pendValid[i] = 1'b1;
                    drvEnt[i] = '{rob: 5'($urandom), rd: 5'($urandom), data: $urandom, we: 1'($urandom)};
                    drvEnt[i].data[31:16] = 16'(seq);
                end
            end
            applyStimulus(pendValid, $urandom_range(0, 99) < 2, acc);
            pendValid = pendValid & ~acc;
        end

        // Drain and confirm every remaining result came out.
        idle(3 * NUM_SRC * DEPTH);
        modelLeft = 0;
        for (int i = 0; i < NUM_SRC; i++) modelLeft += mq[i].size();
        checkOutput("drain_empty", 64'(modelLeft), 64'(0));
        checkOutput("drain_valid", 64'(obsValid), 64'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
